// File: rtl/intc_apb_bridge.sv
// APB3 slave front-end for the interrupt-controller register core: decode, wait states, one-cycle strobes.
// Optional build macro INTC_APB_PROT_EN adds pprot and rejects unprivileged writes.
module intc_apb_bridge #(
   parameter int N      = 8,
   parameter int ADDR_W = 12,
   parameter int WS     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
`ifdef INTC_APB_PROT_EN
   input  logic [2:0]        pprot,
`endif
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              wr_en,
   output logic              rd_en,
   output logic [7:0]        addr,
   output logic [31:0]       wdata,
   input  logic [31:0]       rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_ISSUE  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] WS_C      = 4'(WS);
   localparam int         PRIO_LAST = 32 + 4 * N - 4;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic        err_q, err_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic        wr_en_q, wr_en_d;
   logic        rd_en_q, rd_en_d;

   logic        bad_access;
   int          a8;

   // Illegal transfers never reach the core; the decision is frozen at setup time.
   always_comb begin
      a8         = int'(paddr[7:0]);
      bad_access = 1'b0;
      if (paddr[1:0] != 2'b00)                         bad_access = 1'b1;
      if ((paddr >> 8) != '0)                          bad_access = 1'b1;
      if (!(a8 <= 28 || (a8 >= 32 && a8 <= PRIO_LAST))) bad_access = 1'b1;
      if (pwrite && (a8 == 24 || a8 == 28))            bad_access = 1'b1;
`ifdef INTC_APB_PROT_EN
      if (pwrite && !pprot[0])                         bad_access = 1'b1;
`endif
   end

`ifdef INTC_APB_PROT_EN
   logic unused_prot;
   assign unused_prot = ^pprot[2:1];
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      prdata_d  = 32'h0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr[7:0];
               wdata_d = pwdata;
               write_d = pwrite;
               err_d   = bad_access;
               cnt_d   = 4'd0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!psel) begin
               state_d = S_IDLE;
            end else if (cnt_q != WS_C) begin
               cnt_d = cnt_q + 4'd1;
            end else if (err_q) begin
               state_d   = S_DONE;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else begin
               state_d = S_ISSUE;
               wr_en_d = write_q;
               rd_en_d = !write_q;
            end
         end
         S_ISSUE: begin
            state_d  = S_DONE;
            pready_d = 1'b1;
            prdata_d = write_q ? 32'h0 : rdata;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= 8'h0;
         wdata_q   <= 32'h0;
         prdata_q  <= 32'h0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign wr_en   = wr_en_q;
   assign rd_en   = rd_en_q;
   assign addr    = addr_q;
   assign wdata   = wdata_q;

endmodule

// File: doc/intc_apb_bridge.md
Name: intc_apb_bridge

Overview:
- APB3 slave front-end that sits directly upstream of the interrupt-controller register core.
- Converts APB setup/access transfers into that core's single-cycle wr_en/rd_en strobes, address and write data.
- Captures the core's read data into prdata.
- Decodes the register map and answers illegal accesses with pslverr instead of touching the core.
- Inserts a parameterised number of wait states.

Parameters:
N, 8, interrupt source count; sets the upper bound of the priority register window.
ADDR_W, 12, APB address width; bits above [7:0] must be zero for a legal access.
WS, 0, extra wait cycles in ACCESS before the core strobe (0..15).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
psel  in  1  APB select.
penable  in  1  APB enable (access phase).
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address.
pwdata  in  32  write data.
prdata  out  32  read data; valid only when pready=1.
pready  out  1  transfer complete.
pslverr  out  1  error response; valid only when pready=1.
wr_en  out  1  one-cycle write strobe to the core.
rd_en  out  1  one-cycle read strobe to the core.
addr  out  8  register address to the core.
wdata  out  32  write data to the core.
rdata  in  32  combinational read data from the core.

Behaviour:
- Reset: state=IDLE. prdata, pready, pslverr, wr_en, rd_en, addr, wdata all 0. Wait counter 0.
- All outputs are registered. There is no combinational path from APB inputs to core outputs.
- Legal address decode:
  - paddr[1:0]==0 and paddr[ADDR_W-1:8]==0.
  - addr is 0x00..0x1C, or 0x20..0x20+4N-4.
  - Writes to 0x18 (status) or 0x1C (vector) are illegal; reads there are legal.
  - Reads of 0x08 are legal (the core returns 0).
- IDLE:
  - On psel=1 and penable=0, latch paddr[7:0] into addr, pwdata into wdata, pwrite, and the decode error flag.
  - Clear the counter and go to ACCESS.
- ACCESS:
  - If psel=0, abort to IDLE; no strobe is issued.
  - Otherwise, if counter<WS, increment it.
  - When counter==WS: go to ISSUE if the access is legal, else go to DONE with the error flag set.
- ISSUE:
  - Exactly one cycle; wr_en=1 for writes, rd_en=1 for reads; addr and wdata stable.
  - On the closing edge, capture rdata into prdata for reads (0 for writes) and go to DONE.
  - ISSUE always completes, even if psel drops.
- DONE:
  - Exactly one cycle; pready=1; pslverr equals the error flag.
  - prdata is the captured value, or 0 on error or write.
  - Next state is always IDLE.
  - prdata and pslverr return to 0 after DONE.
- Latency, setup edge to pready: 3+WS cycles for a legal access; 2+WS cycles for an error.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted normally.
- Reset asserted in any state returns immediately to reset values. A strobe cut mid-ISSUE may or may not have reached the core; the bridge guarantees nothing after reset.
- At most one of wr_en or rd_en is high in any cycle. Neither is high outside ISSUE.

Optional Feature:
- Macro: INTC_APB_PROT_EN.
- When defined:
  - Adds input pprot[2:0], latched in IDLE with the address.
  - A write with pprot[0]==0 (unprivileged) is illegal: pslverr=1, no wr_en.
  - Reads are unaffected by pprot.
- When undefined: the pprot port is absent and privilege is never checked.

Test Plan:
- WS=0: write paddr=0x000, pwdata=0x000000A5 (setup at cycle 0) -> wr_en=1, addr=0x00, wdata=0xA5 in cycle 2; pready=1, pslverr=0 in cycle 3. Then read 0x000 -> rd_en in cycle 2 of that transfer; prdata=0xA5 with pready.
- Write 0x018 and write 0x005 -> pready in cycle 2 with pslverr=1; wr_en stays 0; a following read of 0x000 is unchanged.
- N=8 priority window:
  - Write 0x03C data 5 -> legal, then read back 5.
  - Write 0x040 -> pslverr=1.
  - Write 0x100 (upper bits set) -> pslverr=1.
- WS=3: read 0x014 -> pready high exactly 6 cycles after setup; rd_en a single cycle at cycle 5.
- Abort and reset:
  - psel deasserted during ACCESS with WS=2 -> return to IDLE, no strobe, no pready.
  - rst_n pulsed low during ISSUE -> all outputs 0 next sample, state IDLE.
  - A new transfer then completes normally.
- INTC_APB_PROT_EN defined:
  - Write 0x000 with pprot=3'b000 -> pslverr=1, no wr_en.
  - Same write with pprot=3'b001 -> wr_en issued, pslverr=0.
